jam_cost_feeder: RTL
====================

// Module: jam_cost_feeder
// PURPOSE
//   Host-side front end for the JAM job-assignment solver. Loads the 8x8 cost matrix from a
//   valid/ready stream and holds the solver in reset while loading. It then releases the solver
//   and serves Cost lookups on the solver's W/J address. It captures MinCost/MatchCount on Valid
//   and returns them to the host with a valid/ready handshake. A watchdog bounds solver run time.
// PARAMETERS
//   N        8          workers = jobs; table holds N*N entries, row-major (k = W*N + J)
//   COST_W   7          width of one cost entry
//   TIMEOUT  2_000_000  max RUN cycles before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//   CLK              in   1       clock, posedge
//   RST              in   1       synchronous, active-high reset
//   in_valid         in   1       host cost entry valid
//   in_ready         out  1       feeder accepts entry (high only in LOAD)
//   in_data          in   COST_W  cost entry; k-th accepted entry -> cost[k/N][k%N]
//   jam_rst          out  1       reset driven to solver RST
//   W                in   3       solver worker address
//   J                in   3       solver job address
//   Cost             out  COST_W  cost[W][J], combinational (solver samples on negedge)
//   jam_min_cost     in   10      solver MinCost
//   jam_match_count  in   4       solver MatchCount
//   jam_valid        in   1       solver Valid (sticky once set)
//   res_valid        out  1       result available to host
//   res_ready        in   1       host accepts result
//   res_min_cost     out  10      captured MinCost (1023 on timeout)
//   res_match_count  out  4       captured MatchCount (0 on timeout)
//   timeout_err      out  1       result produced by watchdog abort, not by solver
// BEHAVIOUR
//   Reset: state=LOAD, load_cnt=0, jam_rst=1, res_valid=0, res_min_cost=0, res_match_count=0,
//     timeout_err=0, run_cnt=0. Table contents are not reset; they are undefined until loaded.
//   in_ready = (state==LOAD), combinational. An entry is accepted when in_valid & in_ready.
//   LOAD: each accept writes table[load_cnt] and increments load_cnt. jam_rst=1.
//     On the accept with load_cnt==N*N-1: load_cnt<=0, go to START. in_ready is low next cycle.
//   START: jam_rst held 1 for exactly 2 cycles, then go to RUN. jam_rst=0 from the first RUN cycle.
//   RUN: jam_rst=0. run_cnt increments every cycle.
//     On jam_valid=1: capture jam_min_cost/jam_match_count, set timeout_err=0, go to RESULT.
//     Else, if run_cnt==TIMEOUT-1: res_min_cost<=1023, res_match_count<=0, timeout_err<=1,
//     go to RESULT. jam_valid wins if it coincides with the timeout cycle.
//   RESULT: res_valid=1. jam_rst<=1 on entry, so the solver is frozen.
//     Captured values stay stable while res_ready=0.
//     On res_valid & res_ready: res_valid<=0, run_cnt<=0, go to LOAD. timeout_err holds until
//     the next capture.
//   Cost = table[W*N+J] in every state. Any W/J is legal. No write/read hazard exists, because
//     writes happen only while the solver is held in reset.
//   RST in any state (mid-load, mid-run, pending result) aborts the operation immediately.
//     The block returns to reset values on the next edge, and partial loads are discarded.
//   in_valid outside LOAD is ignored (no accept, no side effects). Host gaps in in_valid are
//     legal in LOAD.
// STRUCTURE
//   jam_pkg: N, COST_W, SUM_W=10, MAX_COST=10'd1023, state enum {LOAD,START,RUN,RESULT}.
//   Sub-module jam_cost_table: N*N x COST_W storage, 1 sync write port (we, waddr),
//     1 combinational read port (W, J). The feeder FSM, counters and result regs stay at top level.
// TESTING
//   1 Load 64 entries with random 0-3 cycle in_valid gaps -> exactly 64 accepts; in_ready=0 the
//     cycle after the 64th; jam_rst=1 for 2 more cycles, then 0.
//   2 Load cost[w][j]=w*8+j; drive W=5,J=3 -> Cost=43 in the same cycle; W=7,J=7 -> Cost=63.
//   3 With the real JAM solver and diagonal=0, others=50 -> res_valid, res_min_cost=0,
//     res_match_count=1, timeout_err=0.
//   4 Stub solver asserts jam_valid with 10'd200/4'd3, res_ready held low 20 cycles, stub changes
//     its outputs -> res_* stay 200/3 until the handshake; LOAD and in_ready=1 on the next cycle.
//   5 TIMEOUT=100, stub never valid -> res_valid exactly 100 RUN cycles after jam_rst falls,
//     res_min_cost=1023, res_match_count=0, timeout_err=1.
//   6 RST pulse after 30 loaded entries and again mid-RUN -> next cycle in_ready=1, jam_rst=1,
//     res_valid=0; a fresh 64-entry load then gives the correct result.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared constants, state encoding and address helper for the JAM cost feeder.
// The table is 8x8 row-major, so a worker/job pair maps to one flat cell index.
package jam_pkg;

    localparam int N        = 8;
    localparam int COST_W   = 7;
    localparam int SUM_W    = 10;
    localparam int ADDR_W   = $clog2(N * N);
    localparam logic [SUM_W-1:0] MAX_COST = 10'd1023;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD   = 2'd0;
    localparam state_t ST_START  = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_RESULT = 2'd3;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [2:0] w, input logic [2:0] j);
        return ADDR_W'(ADDR_W'(w) * ADDR_W'(N) + ADDR_W'(j));
    endfunction

endpackage

// File: rtl/jam_cost_table.sv
// N*N cost storage: one synchronous write port, one combinational read port on (W, J).
// Contents are deliberately not reset; they are defined only after a full load.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost
);

    logic [COST_W-1:0] mem_r [N*N];

    // Store one host entry per accepted beat.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign Cost = mem_r[cell_addr(W, J)];

endmodule

// File: rtl/jam_cost_feeder.sv
// Host front end for the JAM solver: loads the cost table, sequences solver reset,
// serves Cost lookups, and returns MinCost/MatchCount (or a watchdog abort) to the host.
module jam_cost_feeder
    import jam_pkg::*;
#(
    parameter int TIMEOUT = 2_000_000
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    output logic              jam_rst,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic [SUM_W-1:0]  jam_min_cost,
    input  logic [3:0]        jam_match_count,
    input  logic              jam_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_min_cost,
    output logic [3:0]        res_match_count,
    output logic              timeout_err
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(N * N - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   load_cnt_r;
    logic                start_cnt_r;
    logic [RUN_W-1:0]    run_cnt_r;
    logic                jam_rst_r;
    logic                res_valid_r;
    logic [SUM_W-1:0]    res_min_cost_r;
    logic [3:0]          res_match_count_r;
    logic                timeout_err_r;
    logic                in_ready_s;
    logic                accept_s;
    logic                load_last_s;
    logic                run_last_s;

    assign in_ready_s  = (state_r == ST_LOAD);
    assign accept_s    = in_valid & in_ready_s;
    assign load_last_s = (load_cnt_r == LOAD_LAST);
    assign run_last_s  = (run_cnt_r == RUN_LAST);

    jam_cost_table u_table (
        .CLK   (CLK),
        .we    (accept_s),
        .waddr (load_cnt_r),
        .wdata (in_data),
        .W     (W),
        .J     (J),
        .Cost  (Cost)
    );

    // Next-state selection; solver Valid takes priority over the watchdog.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && load_last_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_START: begin
                if (start_cnt_r) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_RUN: begin
                if (jam_valid || run_last_s) begin
                    state_next_s = ST_RESULT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RESULT: begin
                if (res_valid_r && res_ready) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_RESULT;
                end
            end
            default: begin
                state_next_s = ST_LOAD;
            end
        endcase
    end

    // FSM, counters and captured result; RST aborts any phase on the next edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r           <= ST_LOAD;
            load_cnt_r        <= '0;
            start_cnt_r       <= 1'b0;
            run_cnt_r         <= '0;
            jam_rst_r         <= 1'b1;
            res_valid_r       <= 1'b0;
            res_min_cost_r    <= '0;
            res_match_count_r <= 4'd0;
            timeout_err_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            // Solver runs only while RUN is the upcoming state, so it is frozen in RESULT.
            jam_rst_r <= (state_next_s != ST_RUN);
            case (state_r)
                ST_LOAD: begin
                    start_cnt_r <= 1'b0;
                    if (accept_s) begin
                        if (load_last_s) begin
                            load_cnt_r <= '0;
                        end else begin
                            load_cnt_r <= load_cnt_r + ADDR_W'(1);
                        end
                    end
                end
                ST_START: begin
                    start_cnt_r <= ~start_cnt_r;
                end
                ST_RUN: begin
                    start_cnt_r <= 1'b0;
                    run_cnt_r   <= run_cnt_r + RUN_W'(1);
                    if (jam_valid) begin
                        res_valid_r       <= 1'b1;
                        res_min_cost_r    <= jam_min_cost;
                        res_match_count_r <= jam_match_count;
                        timeout_err_r     <= 1'b0;
                    end else if (run_last_s) begin
                        res_valid_r       <= 1'b1;
                        res_min_cost_r    <= MAX_COST;
                        res_match_count_r <= 4'd0;
                        timeout_err_r     <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    start_cnt_r <= 1'b0;
                    if (res_valid_r && res_ready) begin
                        res_valid_r <= 1'b0;
                        run_cnt_r   <= '0;
                    end
                end
                default: begin
                    start_cnt_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_s;
    assign jam_rst         = jam_rst_r;
    assign res_valid       = res_valid_r;
    assign res_min_cost    = res_min_cost_r;
    assign res_match_count = res_match_count_r;
    assign timeout_err     = timeout_err_r;

endmodule
